// File: rtl/filter_pixel_sink.sv
// filter_pixel_sink
//   Captures the filtered pixel stream (rd strobe + cl_pixel) into a small
//   FIFO. The FIFO is first-word-fall-through and feeds the image writer
//   over a valid/ready interface. The block also tracks the pixel index
//   within the frame, flags the last pixel of each frame, counts completed
//   frames, and keeps a sticky overflow flag for pixels dropped on a full
//   buffer.
//
//   Optional feature (macro PIXEL_SINK_CHECKSUM_EN):
//     Builds a per-frame 24-bit additive checksum of popped pixels. When the
//     macro is not defined, checksum is tied to 0.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   en, rd          capture enable and filter output strobe
//   cl_pixel        filtered pixel, valid when rd=1
//   out_valid/ready pop handshake; out_pixel is the head of the FIFO
//   out_last        head pixel is the last pixel of its frame
//   frame_done      one-cycle pulse after the last pixel of a frame is popped
//   frame_cnt       number of completed frames (wraps)
//   pix_cnt         index of the head pixel within the current frame
//   overflow        sticky; a pixel was dropped
//   checksum        checksum of the last completed frame
module filter_pixel_sink #(
  parameter int DEPTH        = 16,
  parameter int FRAME_PIXELS = 74304,
  parameter int CW           = $clog2(FRAME_PIXELS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          rd,
  input  logic [7:0]    cl_pixel,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_pixel,
  output logic          out_last,
  output logic          frame_done,
  output logic [15:0]   frame_cnt,
  output logic [CW-1:0] pix_cnt,
  output logic          overflow,
  output logic [23:0]   checksum
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_OCC = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_PIX = CW'(FRAME_PIXELS - 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ;
  logic          full, push, drop, pop, last_pop;

  // A pop in the same cycle never makes room for a push into a full FIFO.
  assign full     = (occ == FULL_OCC);
  assign push     = en && rd && !full;
  assign drop     = en && rd && full;
  assign out_valid = (occ != '0);
  assign pop      = out_valid && out_ready;
  assign out_pixel = mem[rd_ptr];
  assign out_last = out_valid && (pix_cnt == LAST_PIX);
  assign last_pop = pop && (pix_cnt == LAST_PIX);

  // Storage carries no reset; contents are don't-care until occupancy covers them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cl_pixel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      occ <= occ + 1'b1;
      else if (!push && pop) occ <= occ - 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  // Frame position tracks pops only; it is independent of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt    <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= last_pop;
      if (pop) pix_cnt <= last_pop ? '0 : pix_cnt + 1'b1;
      if (last_pop) frame_cnt <= frame_cnt + 1'b1;
    end
  end

`ifdef PIXEL_SINK_CHECKSUM_EN
  logic [23:0] acc, cks_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      cks_q <= '0;
    end else if (pop) begin
      if (last_pop) begin
        cks_q <= acc + {16'h0, out_pixel};
        acc   <= '0;
      end else begin
        acc   <= acc + {16'h0, out_pixel};
      end
    end
  end

  assign checksum = cks_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: doc/filter_pixel_sink.md
Name: filter_pixel_sink

Overview:
- Stage directly downstream of the parallel filter top.
- Captures the filtered pixel stream, which arrives as the `rd` strobe plus the 8-bit `cl_pixel`, into a small FIFO.
- Re-presents the pixels on a valid/ready interface to the image writer.
- Tracks frame position, flags the last pixel of each frame, and reports overflow when the filter pushes into a full buffer.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- FRAME_PIXELS, 74304, pixels per frame (16 banks x 4644); at least 2.
- CW, $clog2(FRAME_PIXELS), width of the pixel counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  capture enable; same signal that enables the filter.
- rd  input  1  filter output strobe; `cl_pixel` is valid in that cycle.
- cl_pixel  input  8  filtered pixel.
- out_valid  output  1  `out_pixel` holds a pixel.
- out_ready  input  1  consumer accepts the pixel this cycle.
- out_pixel  output  8  head-of-FIFO pixel.
- out_last  output  1  the head pixel is the last pixel of its frame.
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is popped.
- frame_cnt  output  16  count of completed frames; wraps at 65535.
- pix_cnt  output  CW  index of the head pixel within the current frame.
- overflow  output  1  sticky: a pixel was dropped.
- checksum  output  24  frame checksum (see Optional Feature).

Behaviour:
- Reset (asynchronous on `rst_n` low, takes effect immediately):
  - pointers and occupancy go to 0;
  - out_valid=0, out_last=0, frame_done=0, frame_cnt=0, pix_cnt=0, overflow=0, checksum=0;
  - `out_pixel` is don't-care while out_valid=0.
  - Reset mid-frame discards all buffered pixels and restarts counting at pixel 0.
- Push: occurs on a clk edge when en=1, rd=1 and the FIFO is not full.
  - rd is ignored while en=0 and does not set overflow.
- Drop: rd=1, en=1 and FIFO full.
  - The pixel is dropped and overflow is set to 1 on the next edge.
  - overflow stays 1 until reset.
  - A pop in the same cycle does not free space for the dropped push.
- Pop: occurs when out_valid=1 and out_ready=1.
- Output is first-word-fall-through:
  - out_valid = (occupancy != 0);
  - out_pixel = storage[rd_ptr].
  - out_pixel and out_last must hold stable while out_valid=1 and out_ready=0.
- Latency: a pixel pushed at edge N is visible with out_valid=1 after edge N. There is no bypass into an empty FIFO in the same cycle.
- Simultaneous push and pop when not full: occupancy is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full and empty are decided by a separate occupancy counter of log2(DEPTH)+1 bits.
- pix_cnt increments on each pop. On a pop with pix_cnt == FRAME_PIXELS-1 it wraps to 0.
- out_last = out_valid && (pix_cnt == FRAME_PIXELS-1).
- When the last pixel is popped:
  - frame_done is 1 for exactly the following cycle;
  - frame_cnt increments on that same edge.
- Counting is independent of `en`: the FIFO keeps draining when en=0.

Optional Feature:
- Macro: PIXEL_SINK_CHECKSUM_EN.
- Defined:
  - a 24-bit accumulator adds each popped pixel, zero-extended, modulo 2^24;
  - on the pop of the last pixel, `checksum` latches accumulator + that pixel and the accumulator clears to 0;
  - `checksum` holds until the next frame completes.
- Not defined: `checksum` is tied to 0 and no accumulator logic exists.

Test Plan:
1. Reset, then en=1 with one rd pulse carrying cl_pixel=8'hA5, out_ready=0 → out_valid=1 and out_pixel=A5 from the cycle after the push; holds while out_ready=0; one out_ready cycle → out_valid=0, pix_cnt=1.
2. DEPTH=16, out_ready=0, 17 consecutive rd pulses with pixels 0..16 → the first 16 are stored and overflow=1 after the 17th edge; draining then yields 0..15 in order, pixel 16 never appears, overflow stays 1.
3. FRAME_PIXELS=4, out_ready=1, 8 pixels → out_last high on the 4th and 8th popped pixels; frame_done pulses twice, one cycle each; frame_cnt goes 0→1→2; pix_cnt returns to 0.
4. en=0 with rd toggling on 5 cycles → nothing is stored, out_valid stays 0, overflow stays 0. Then en=1 with continuous rd and out_ready=1 → pushes and pops every cycle with occupancy steady at 1.
5. Mid-frame: 3 pixels buffered, pix_cnt=2, then rst_n pulsed low between edges → all outputs are 0 immediately; after release the next pushed pixel is reported with pix_cnt=0.
6. With PIXEL_SINK_CHECKSUM_EN and FRAME_PIXELS=4, pixels FF,FF,01,02 → checksum=24'h000201 one edge after the last pop; the next frame 00,00,00,03 → checksum=24'h000003.
